// File: rtl/alu_op_scheduler_if.sv
// ALU issue/result bus between the op scheduler (master) and an external ALU (slave).
// NBITS must match the scheduler's NBITS parameter.
interface alu_op_scheduler_if #(
  parameter int NBITS = 3
);
  logic [1:0]       alu_f;
  logic [NBITS-1:0] alu_a;
  logic [NBITS-1:0] alu_b;
  logic             alu_valid;
  logic [NBITS-1:0] alu_y;
  logic             alu_ovf;

  modport master (
    output alu_f, alu_a, alu_b, alu_valid,
    input  alu_y, alu_ovf
  );

  modport slave (
    input  alu_f, alu_a, alu_b, alu_valid,
    output alu_y, alu_ovf
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Sequences single or sweep (ops 0..3) ALU operations, banks results and drives a 7-seg digit.
// Latency: issue 1 cycle after a start rise; each op costs 1+ALU_LAT busy cycles.
// Backpressure: none; start rises while running are dropped, abort cancels a run.
module alu_op_scheduler #(
  parameter int ALU_LAT = 1,
  parameter int NBITS   = 3
) (
  input  logic                      clk_2,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      sweep,
  input  logic [1:0]                op_sel,
  input  logic [NBITS-1:0]          a,
  input  logic [NBITS-1:0]          b,
  input  logic                      abort,
  input  logic [1:0]                disp_sel,
  alu_op_scheduler_if.master        alu,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                res_vld,
  output logic [7:0]                seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(ALU_LAT - 1);

  state_t           state;
  logic             start_q;
  logic             start_armed;
  logic             sweep_q;
  logic [1:0]       op_cnt;
  logic [2:0]       wait_cnt;
  logic [NBITS:0]   bank [0:3];
  logic             start_rise;

  // start_armed blocks a run when start is already high as reset releases;
  // start must be seen low at least once before a rise counts.
  assign start_rise = start & ~start_q & start_armed;
  assign alu.alu_f  = op_cnt;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      start_armed   <= 1'b0;
      sweep_q       <= 1'b0;
      op_cnt        <= 2'd0;
      wait_cnt      <= 3'd0;
      res_vld       <= 4'd0;
      alu.alu_a     <= '0;
      alu.alu_b     <= '0;
      alu.alu_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else begin
      start_q     <= start;
      start_armed <= start_armed | ~start;
      case (state)
        IDLE: begin
          if (start_rise) begin
            alu.alu_a     <= a;
            alu.alu_b     <= b;
            sweep_q       <= sweep;
            res_vld       <= 4'd0;
            op_cnt        <= sweep ? 2'd0 : op_sel;
            alu.alu_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          alu.alu_valid <= 1'b0;
          wait_cnt      <= 3'd0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // abort takes priority over the capture on the final WAIT edge
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            bank[op_cnt]    <= {alu.alu_ovf, alu.alu_y};
            res_vld[op_cnt] <= 1'b1;
            if (sweep_q && (op_cnt != 2'd3)) begin
              op_cnt        <= op_cnt + 2'd1;
              alu.alu_valid <= 1'b1;
              state         <= ISSUE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NBITS:0] disp_entry;
  logic [31:0]    disp_val;
  logic [6:0]     digit;

  // Values above 7 (only possible when NBITS > 3) have no glyph and show blank.
  always_comb begin
    disp_entry = bank[disp_sel];
    disp_val   = 32'(disp_entry[NBITS-1:0]);
    digit      = 7'h00;
    case (disp_val)
      32'd0:   digit = 7'h3F;
      32'd1:   digit = 7'h06;
      32'd2:   digit = 7'h5B;
      32'd3:   digit = 7'h4F;
      32'd4:   digit = 7'h66;
      32'd5:   digit = 7'h6D;
      32'd6:   digit = 7'h7D;
      32'd7:   digit = 7'h07;
      default: digit = 7'h00;
    endcase
    seg = res_vld[disp_sel] ? {disp_entry[NBITS], digit} : 8'h00;
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench: two schedulers (ALU_LAT 1 and 3) share stimulus, each with its own ALU model.
module tb_alu_op_scheduler;

  logic       clk_2;
  logic       reset_n;
  logic       start, sweep, abort;
  logic [1:0] op_sel, disp_sel;
  logic [2:0] a, b;
  logic       busy1, done1, busy3, done3;
  logic [3:0] res_vld1, res_vld3;
  logic [7:0] seg1, seg3;

  alu_op_scheduler_if #(.NBITS(3)) bus1 ();
  alu_op_scheduler_if #(.NBITS(3)) bus3 ();

  alu_op_scheduler #(.ALU_LAT(1), .NBITS(3)) u_dut1 (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .sweep(sweep), .op_sel(op_sel),
    .a(a), .b(b), .abort(abort), .disp_sel(disp_sel), .alu(bus1.master),
    .busy(busy1), .done(done1), .res_vld(res_vld1), .seg(seg1)
  );

  alu_op_scheduler #(.ALU_LAT(3), .NBITS(3)) u_dut3 (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .sweep(sweep), .op_sel(op_sel),
    .a(a), .b(b), .abort(abort), .disp_sel(disp_sel), .alu(bus3.master),
    .busy(busy3), .done(done3), .res_vld(res_vld3), .seg(seg3)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Reference ALU: {ovf, y}; ovf = carry for ADD, borrow for SUB.
  function automatic logic [3:0] alu_calc(input logic [1:0] f, input logic [2:0] x, input logic [2:0] y);
    logic [3:0] s;
    case (f)
      2'd0:    s = {1'b0, x & y};
      2'd1:    s = {1'b0, x | y};
      2'd2:    s = {1'b0, x} + {1'b0, y};
      default: s = {(x < y), 3'(x - y)};
    endcase
    return s;
  endfunction

  // ALU models: result is correct only during the last latency cycle, inverted otherwise.
  logic [3:0] m1_res, m3_res;
  int         m1_cnt, m3_cnt;

  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      m1_res <= 4'd0; m1_cnt <= 0;
      m3_res <= 4'd0; m3_cnt <= 0;
    end else begin
      if (bus1.alu_valid) begin
        m1_res <= alu_calc(bus1.alu_f, bus1.alu_a, bus1.alu_b);
        m1_cnt <= 1;
      end else if (m1_cnt > 0) m1_cnt <= m1_cnt - 1;
      if (bus3.alu_valid) begin
        m3_res <= alu_calc(bus3.alu_f, bus3.alu_a, bus3.alu_b);
        m3_cnt <= 3;
      end else if (m3_cnt > 0) m3_cnt <= m3_cnt - 1;
    end
  end

  assign {bus1.alu_ovf, bus1.alu_y} = (m1_cnt == 1) ? m1_res : ~m1_res;
  assign {bus3.alu_ovf, bus3.alu_y} = (m3_cnt == 1) ? m3_res : ~m3_res;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  int         iss3, iss1, busy_c1, busy_c3, done_c1, done_c3, done_k3, stray;
  int         iss_k[4];
  logic [1:0] iss_f[4];
  logic [7:0] seg_exp[4];

  initial begin
    reset_n = 1'b0; start = 1'b0; sweep = 1'b0; abort = 1'b0;
    op_sel = 2'd0; disp_sel = 2'd0; a = 3'd0; b = 3'd0;

    // reset state
    step(2);
    chk("rst_busy",  32'(busy3), 32'd0);
    chk("rst_valid", 32'(bus3.alu_valid), 32'd0);
    chk("rst_f",     32'(bus3.alu_f), 32'd0);
    chk("rst_vld",   32'(res_vld3), 32'd0);
    chk("rst_seg",   32'(seg3), 32'h00);
    chk("rst_done",  32'(done3), 32'd0);
    reset_n = 1'b1;
    step(2);

    // single ADD 1+2 on both latencies
    a = 3'd1; b = 3'd2; sweep = 1'b0; op_sel = 2'd2; disp_sel = 2'd2;
    start = 1'b1;
    step(1);
    chk("s_valid1", 32'(bus1.alu_valid), 32'd1);
    chk("s_f1",     32'(bus1.alu_f), 32'd2);
    chk("s_a1",     32'(bus1.alu_a), 32'd1);
    chk("s_b1",     32'(bus1.alu_b), 32'd2);
    chk("s_busy1",  32'(busy1), 32'd1);
    step(1);
    chk("s_valid1_off", 32'(bus1.alu_valid), 32'd0);
    chk("s_busy1_wait", 32'(busy1), 32'd1);
    chk("s_done1_early", 32'(done1), 32'd0);
    step(1);
    chk("s_done1",  32'(done1), 32'd1);
    chk("s_vld1",   32'(res_vld1), 32'h4);
    chk("s_busy1_done", 32'(busy1), 32'd0);
    step(1);
    chk("s_done1_off", 32'(done1), 32'd0);
    chk("s_seg1",   32'(seg1), 32'h4F);
    step(1);
    chk("s_done3",  32'(done3), 32'd1);
    chk("s_vld3",   32'(res_vld3), 32'h4);
    chk("s_seg3",   32'(seg3), 32'h4F);
    start = 1'b0;
    step(2);

    // sweep 5,3 with a second start rise while busy
    a = 3'd5; b = 3'd3; sweep = 1'b1;
    iss3 = 0; busy_c1 = 0; busy_c3 = 0; done_c1 = 0; done_c3 = 0; done_k3 = 0;
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (bus3.alu_valid) begin
        if (iss3 < 4) begin iss_k[iss3] = k; iss_f[iss3] = bus3.alu_f; end
        iss3++;
      end
      if (busy1) busy_c1++;
      if (busy3) busy_c3++;
      if (done1) done_c1++;
      if (done3) begin done_c3++; done_k3 = k; end
      if (k == 2) start = 1'b0;
      if (k == 3) start = 1'b1;
    end
    chk("w_issues3", 32'(iss3), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_issue_cyc%0d", i), 32'(iss_k[i]), 32'(1 + 4 * i));
      chk($sformatf("w_issue_f%0d", i),   32'(iss_f[i]), 32'(i));
    end
    chk("w_busy3",  32'(busy_c3), 32'd16);
    chk("w_done3",  32'(done_c3), 32'd1);
    chk("w_donek3", 32'(done_k3), 32'd17);
    chk("w_busy1",  32'(busy_c1), 32'd8);
    chk("w_done1",  32'(done_c1), 32'd1);
    chk("w_vld3",   32'(res_vld3), 32'hF);
    chk("w_vld1",   32'(res_vld1), 32'hF);
    seg_exp[0] = 8'h06; seg_exp[1] = 8'h07; seg_exp[2] = 8'hBF; seg_exp[3] = 8'h5B;
    for (int i = 0; i < 4; i++) begin
      disp_sel = 2'(i);
      #1;
      chk($sformatf("w_seg3_%0d", i), 32'(seg3), 32'(seg_exp[i]));
    end

    // sweep 1,3: SUB underflows to 6
    start = 1'b0;
    step(2);
    a = 3'd1; b = 3'd3;
    start = 1'b1;
    step(1);
    chk("o_vld_clr", 32'(res_vld3), 32'd0);
    step(24);
    chk("o_vld3", 32'(res_vld3), 32'hF);
    disp_sel = 2'd3;
    #1;
    chk("o_seg3_sub", 32'(seg3), 32'hFD);
    chk("o_seg1_sub", 32'(seg1), 32'hFD);
    disp_sel = 2'd2;
    #1;
    chk("o_seg3_add", 32'(seg3), 32'h66);

    // abort on the final WAIT cycle of op 2
    start = 1'b0;
    step(2);
    a = 3'd5; b = 3'd3;
    iss3 = 0; iss1 = 0; done_c1 = 0; done_c3 = 0;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bus3.alu_valid) iss3++;
      if (bus1.alu_valid) iss1++;
      if (done1) done_c1++;
      if (done3) done_c3++;
      if (k == 13) begin
        chk("a_busy3", 32'(busy3), 32'd0);
        abort = 1'b0;
      end
      if (k == 12) abort = 1'b1;
    end
    chk("a_issues3", 32'(iss3), 32'd3);
    chk("a_vld3",    32'(res_vld3), 32'h3);
    chk("a_done3",   32'(done_c3), 32'd0);
    chk("a_issues1", 32'(iss1), 32'd4);
    chk("a_done1",   32'(done_c1), 32'd1);
    chk("a_vld1",    32'(res_vld1), 32'hF);
    disp_sel = 2'd2;
    #1;
    chk("a_seg3_blank", 32'(seg3), 32'h00);
    disp_sel = 2'd0;
    #1;
    chk("a_seg3_kept", 32'(seg3), 32'h06);

    // reset mid-WAIT with start held high
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(2);
    chk("r_busy_pre", 32'(busy3), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("r_busy",  32'(busy3), 32'd0);
    chk("r_valid", 32'(bus3.alu_valid), 32'd0);
    chk("r_f",     32'(bus3.alu_f), 32'd0);
    chk("r_a",     32'(bus3.alu_a), 32'd0);
    chk("r_vld",   32'(res_vld3), 32'd0);
    chk("r_seg",   32'(seg3), 32'h00);
    step(2);
    reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (busy3 || done3 || bus3.alu_valid || busy1 || done1) stray++;
    end
    chk("r_no_run", 32'(stray), 32'd0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("r_fresh_start", 32'(bus3.alu_valid), 32'd1);
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter ALU_LAT, default 1, range 1..7: ALU latency in cycles from operand issue to valid result.
REQ-002 Parameter NBITS, default 3: operand/result width.
REQ-003 clk_2  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level input (switch); a rising edge requests a run.
REQ-006 sweep  in  1  1 = run ops 0..3 in order; 0 = run op_sel only; sampled with start.
REQ-007 op_sel  in  2  op for single mode: 0 AND, 1 OR, 2 ADD, 3 SUB.
REQ-008 a, b  in  NBITS  operands, sampled with start.
REQ-009 abort  in  1  synchronous cancel of a run in progress.
REQ-010 disp_sel  in  2  result-bank entry shown on seg.
REQ-011 alu_f  out  2  op code to ALU.
REQ-012 alu_a, alu_b  out  NBITS  operands to ALU.
REQ-013 alu_valid  out  1  one-cycle issue strobe.
REQ-014 alu_y  in  NBITS  ALU result.
REQ-015 alu_ovf  in  1  ALU overflow/underflow flag.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  one-cycle run-complete pulse.
REQ-018 res_vld  out  4  per-op result-valid bits.
REQ-019 seg  out  8  7-segment drive; bit 7 = dp, bits 6:0 = gfedcba.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-021 A start rise SHALL be detected from a registered copy of start (prev 0, now 1).
REQ-022 In IDLE on a start rise: latch a, b, sweep, op_sel; clear res_vld; set op counter to 0 (sweep) or op_sel (single); next state ISSUE.
REQ-023 ISSUE lasts exactly 1 cycle with alu_valid=1; alu_f = op counter, alu_a/alu_b = latched operands.
REQ-024 alu_f, alu_a, alu_b SHALL be held stable from ISSUE through the final WAIT cycle.
REQ-025 WAIT lasts exactly ALU_LAT cycles; alu_y/alu_ovf SHALL be captured into bank[op] on the edge ending the last WAIT cycle, setting res_vld[op].
REQ-026 After capture: sweep and op<3 -> increment op, go to ISSUE; otherwise go to DONE.
REQ-027 DONE lasts 1 cycle with done=1, then IDLE.
REQ-028 busy=1 in ISSUE and WAIT only.
REQ-029 Cycle cost: single run = 1+ALU_LAT cycles busy; sweep = 4*(1+ALU_LAT).
REQ-030 Start rises while not in IDLE SHALL be ignored and not queued.
REQ-031 abort=1 in ISSUE or WAIT SHALL force IDLE on the next edge: no capture that edge, no done pulse, previously captured entries kept.
REQ-032 abort and the final capture in the same cycle: abort wins, no capture.
REQ-033 abort in IDLE or DONE SHALL have no effect.
REQ-034 Bank entries are written only by capture and hold value otherwise.
REQ-035 seg[6:0] SHALL encode bank[disp_sel] value 0..7 as 3F,06,5B,4F,66,6D,7D,07 (hex); seg[7] = stored ovf.
REQ-036 seg SHALL be 8'h00 when res_vld[disp_sel]=0; seg is combinational from disp_sel and the bank.

Reset
REQ-037 reset_n=0 SHALL immediately force IDLE, registered start copy 0, op counter 0, res_vld 0, bank 0, alu_f/alu_a/alu_b 0, alu_valid 0, busy 0, done 0, seg 8'h00.
REQ-038 Reset asserted mid-run SHALL discard the run; no done pulse follows deassertion.
REQ-039 start held high through reset release SHALL NOT start a run; a fresh 0->1 is required.

Verification
REQ-040 ALU_LAT=1, single, op_sel=2, a=1, b=2, ALU model returns 3 -> alu_valid 1 cycle after the rise, capture 2 cycles after, done next; disp_sel=2 -> seg=8'h4F.
REQ-041 ALU_LAT=3, sweep, a=5, b=3 -> four ISSUE pulses 4 cycles apart; alu_f 0,1,2,3; res_vld=4'hF; done once after 16 busy cycles.
REQ-042 Sweep with the ALU model flagging SUB ovf (a=1, b=3, y=6) -> disp_sel=3 shows seg=8'hFD.
REQ-043 Second start rise during busy -> ignored; exactly one done.
REQ-044 abort in the WAIT of op 2 during a sweep -> IDLE next cycle; res_vld=4'b0011; no done; seg blank for disp_sel=2.
REQ-045 reset_n pulsed low mid-WAIT with start held high -> all outputs 0; no run after release until start toggles.
